ifu_prefetch: RTL and testbench

Parametrised instruction-fetch unit with a decoupling instruction queue, placed between the PC/redirect logic of the multicycle core and the IDU. It issues word reads on an AXI4-Lite-style read channel and runs ahead of decode up to `DEPTH` instructions. It presents fetched instructions to the IDU through a valid/ready handshake. A redirect from EXU or WBU flushes all queued and in-flight fetches, and a bus error is carried with the instruction as a fault.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fifo.sv | 59 +++++
 rtl/ifu_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_ifu_prefetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch prefetch unit.
//   ifu_state_t : fetch FSM state encoding
//   ifu_entry_t : one queued instruction {pc, ins, fault} at 32-bit XLEN
//   RESP_OKAY   : read response code for a successful access
package ifu_pkg;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      IFU_IDLE  = 2'd0,
      IFU_DELAY = 2'd1,
      IFU_AR    = 2'd2,
      IFU_R     = 2'd3
   } ifu_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        fault;
   } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO used as the fetch-to-decode instruction queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst      : clock, async active-high reset
//   push, din     : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   flush         : empty the queue; wins over push/pop
//   full, empty   : occupancy flags
//   count         : number of entries held
//   head          : oldest entry (registered storage, no bypass)
module ifu_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with a decoupling instruction queue. Issues one
// word read at a time on an AXI4-Lite-style read channel, runs ahead of
// decode up to DEPTH instructions and hands them to the IDU via valid/ready.
// A redirect flushes the queue and discards any outstanding response; a
// non-OKAY response is queued as a fault and halts fetch until a redirect.
//
// Build option: IFU_RANDOM_DELAY_EN (simulation only) inserts a random
// 0..31 cycle wait before each read address to stress the IDU handshake.
//
// Ports:
//   clk, rst                   : clock, async active-high reset
//   redirect_valid/_pc         : flush and restart fetch at redirect_pc
//   ifu_araddr/arvalid/arready : read address channel
//   ifu_rdata/rvalid/rresp/rready : read data channel
//   ifu_valid, idu_ready       : instruction handshake to the IDU
//   ins, out, ifu_fault        : head instruction, its PC, bus-error flag
//
// state     | meaning
// ----------+-------------------------------------------------------
// IFU_IDLE  | waiting for queue room (and not halted) to issue a read
// IFU_DELAY | random pre-issue wait (IFU_RANDOM_DELAY_EN builds only)
// IFU_AR    | arvalid held with araddr until arready
// IFU_R     | rready high, waiting for the read response
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] ifu_araddr,
   output logic            ifu_arvalid,
   input  logic            ifu_arready,
   input  logic [XLEN-1:0] ifu_rdata,
   input  logic            ifu_rvalid,
   input  logic [1:0]      ifu_rresp,
   output logic            ifu_rready,
   output logic            ifu_valid,
   input  logic            idu_ready,
   output logic [31:0]     ins,
   output logic [XLEN-1:0] out,
   output logic            ifu_fault
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = XLEN + 32 + 1;

   ifu_state_t      state;
   logic [XLEN-1:0] fetch_pc;
   logic            drop;
   logic            halted;

   logic            q_full;
   logic            q_empty;
   logic [CW-1:0]   q_count;
   logic [EW-1:0]   q_head;
   logic            rsp_fault;
   logic            push_en;
   logic            can_issue;

   // A response is queued only if it belongs to the current fetch stream:
   // not flagged for dropping and not overtaken by a redirect this cycle.
   assign rsp_fault = (ifu_rresp != RESP_OKAY);
   assign push_en   = (state == IFU_R) && ifu_rvalid && !drop && !redirect_valid;
   assign can_issue = !halted && (q_count < CW'(DEPTH));

`ifdef IFU_RANDOM_DELAY_EN
   logic [4:0] dly_cnt;
`else
   // Back-to-back issue straight out of R keeps zero-wait throughput at one
   // instruction per two cycles; room is reserved for the entry being pushed.
   logic can_chain;
   assign can_chain = !rsp_fault && (q_count + CW'(1) < CW'(DEPTH));
`endif

   ifu_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en && !q_full),
      .pop   (ifu_valid && idu_ready),
      .flush (redirect_valid),
      .din   ({ifu_araddr, ifu_rdata[31:0], rsp_fault}),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count),
      .head  (q_head)
   );

   assign ifu_valid = !q_empty;
   assign out       = q_empty ? '0 : q_head[EW-1 -: XLEN];
   assign ins       = q_empty ? '0 : q_head[32:1];
   assign ifu_fault = q_empty ? 1'b0 : q_head[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IFU_IDLE;
         ifu_arvalid <= 1'b0;
         ifu_rready  <= 1'b0;
         ifu_araddr  <= RESET_PC;
         fetch_pc    <= RESET_PC;
         drop        <= 1'b0;
         halted      <= 1'b0;
`ifdef IFU_RANDOM_DELAY_EN
         dly_cnt     <= '0;
`endif
      end else begin
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halted   <= 1'b0;
         end

         case (state)
            IFU_IDLE: begin
               if (!redirect_valid && can_issue) begin
`ifdef IFU_RANDOM_DELAY_EN
                  state   <= IFU_DELAY;
                  dly_cnt <= 5'($random);
`else
                  state       <= IFU_AR;
                  ifu_arvalid <= 1'b1;
                  ifu_araddr  <= fetch_pc;
`endif
               end
            end

`ifdef IFU_RANDOM_DELAY_EN
            IFU_DELAY: begin
               if (dly_cnt == 5'd0) begin
                  state       <= IFU_AR;
                  ifu_arvalid <= 1'b1;
                  ifu_araddr  <= redirect_valid ? redirect_pc : fetch_pc;
               end else begin
                  dly_cnt <= dly_cnt - 5'd1;
               end
            end
`endif

            // Address stays put across a redirect; the response is dropped instead.
            IFU_AR: begin
               if (redirect_valid) drop <= 1'b1;
               if (ifu_arready) begin
                  state       <= IFU_R;
                  ifu_arvalid <= 1'b0;
                  ifu_rready  <= 1'b1;
               end
            end

            IFU_R: begin
               if (ifu_rvalid) begin
                  ifu_rready <= 1'b0;
                  drop       <= 1'b0;
                  state      <= IFU_IDLE;
                  if (push_en) begin
                     fetch_pc <= fetch_pc + XLEN'(4);
                     if (rsp_fault) halted <= 1'b1;
`ifndef IFU_RANDOM_DELAY_EN
                     if (can_chain) begin
                        state       <= IFU_AR;
                        ifu_arvalid <= 1'b1;
                        ifu_araddr  <= fetch_pc + XLEN'(4);
                     end
`endif
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end

            default: state <= IFU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;
   import ifu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] ifu_araddr;
   logic        ifu_arvalid;
   logic        ifu_arready;
   logic [31:0] ifu_rdata;
   logic        ifu_rvalid;
   logic [1:0]  ifu_rresp;
   logic        ifu_rready;
   logic        ifu_valid;
   logic        idu_ready;
   logic [31:0] ins;
   logic [31:0] out;
   logic        ifu_fault;

   always #5 clk = ~clk;

   ifu_prefetch #(
      .XLEN     (32),
      .RESET_PC (32'h8000_0000),
      .DEPTH    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifu_araddr     (ifu_araddr),
      .ifu_arvalid    (ifu_arvalid),
      .ifu_arready    (ifu_arready),
      .ifu_rdata      (ifu_rdata),
      .ifu_rvalid     (ifu_rvalid),
      .ifu_rresp      (ifu_rresp),
      .ifu_rready     (ifu_rready),
      .ifu_valid      (ifu_valid),
      .idu_ready      (idu_ready),
      .ins            (ins),
      .out            (out),
      .ifu_fault      (ifu_fault)
   );

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          pop_cnt  = 0;
   int          pop_cyc[$];
   ifu_entry_t  exp_q[$];
   logic [31:0] ar_q[$];
   bit          ar_fire  = 0;
   bit          r_fire   = 0;
   logic [31:0] ar_addr_lat = '0;
   bit          ar_stall = 0;
   bit          err_en   = 0;
   logic [31:0] err_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic f);
      ifu_entry_t e;
      e.pc    = pc;
      e.ins   = ~pc;
      e.fault = f;
      exp_q.push_back(e);
   endtask

   // Monitor: handshakes seen here complete at the following rising edge.
   always @(negedge clk) begin
      ifu_entry_t e;
      ar_fire = !rst && ifu_arvalid && ifu_arready;
      r_fire  = !rst && ifu_rvalid && ifu_rready;
      if (ar_fire) begin
         ar_addr_lat = ifu_araddr;
         ar_q.push_back(ifu_araddr);
      end
      if (!rst && ifu_valid && idu_ready) begin
         pop_cyc.push_back(cyc);
         pop_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ins: got pc %h with nothing expected", out);
         end else begin
            e = exp_q.pop_front();
            check32("ins_pc", out, e.pc);
            check32("ins_word", ins, e.ins);
            check32("ins_fault", {31'b0, ifu_fault}, {31'b0, e.fault});
         end
      end
   end

   // Zero-wait memory: rdata = ~address, optional error response at err_addr.
   initial begin
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            ifu_rvalid = 1'b0;
         end else begin
            if (r_fire) ifu_rvalid = 1'b0;
            if (ar_fire) begin
               ifu_rvalid = 1'b1;
               ifu_rdata  = ~ar_addr_lat;
               ifu_rresp  = (err_en && ar_addr_lat == err_addr) ? 2'b10 : 2'b00;
            end
         end
         ifu_arready = !ar_stall;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick(1);
      redirect_valid = 1'b0;
   endtask

   task automatic wait_pops(input int target, input int budget);
      int k = 0;
      while (pop_cnt < target && k < budget) begin
         tick(1);
         k++;
      end
      idu_ready = 1'b0;
      check32("pop_count", pop_cnt, target);
   endtask

   initial begin
      int n;
      int t;
      int seen;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      idu_ready      = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      check32("rst_arvalid", {31'b0, ifu_arvalid}, 32'd0);
      check32("rst_rready",  {31'b0, ifu_rready}, 32'd0);
      check32("rst_araddr",  ifu_araddr, 32'h8000_0000);
      check32("rst_valid",   {31'b0, ifu_valid}, 32'd0);
      check32("rst_ins",     ins, 32'd0);
      check32("rst_out",     out, 32'd0);
      check32("rst_fault",   {31'b0, ifu_fault}, 32'd0);

      rst = 1'b0;
      tick(1);
      check32("first_arvalid", {31'b0, ifu_arvalid}, 32'd1);
      check32("first_araddr",  ifu_araddr, 32'h8000_0000);

      // Back-pressure: queue fills with exactly DEPTH fetches.
      tick(40);
      check32("bp_ar_count", ar_q.size(), 32'd4);
      check32("bp_arvalid",  {31'b0, ifu_arvalid}, 32'd0);
      check32("bp_valid",    {31'b0, ifu_valid}, 32'd1);
      for (int i = 0; i < 12; i++) push_exp(32'h8000_0000 + 32'(4 * i), 1'b0);
      idu_ready = 1'b1;
      wait_pops(12, 200);
      check32("bp_resume_addr", ar_q[4], 32'h8000_0010);
      for (int i = 9; i < 12; i++) check32("stream_rate", pop_cyc[i] - pop_cyc[i-1], 32'd2);

      // Redirect while the address is stalled.
      tick(20);
      ar_stall = 1;
      exp_q.delete();
      do_redirect(32'h8000_0200);
      tick(4);
      check32("stall_arvalid", {31'b0, ifu_arvalid}, 32'd1);
      check32("stall_araddr",  ifu_araddr, 32'h8000_0200);
      do_redirect(32'h8000_1000);
      tick(2);
      check32("hold_arvalid", {31'b0, ifu_arvalid}, 32'd1);
      check32("hold_araddr",  ifu_araddr, 32'h8000_0200);
      n = ar_q.size();
      for (int i = 0; i < 3; i++) push_exp(32'h8000_1000 + 32'(4 * i), 1'b0);
      ar_stall  = 0;
      idu_ready = 1'b1;
      t = pop_cnt + 3;
      wait_pops(t, 100);
      check32("stalled_ar", ar_q[n], 32'h8000_0200);
      check32("redir_ar",   ar_q[n+1], 32'h8000_1000);

      // Redirect coincident with rvalid.
      tick(20);
      exp_q.delete();
      do_redirect(32'h8000_2000);
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         if (ifu_rvalid && ifu_rready) begin
            seen++;
            if (seen == 2) break;
         end
         tick(1);
      end
      check32("rv_seen",      seen, 32'd2);
      check32("rv_pre_valid", {31'b0, ifu_valid}, 32'd1);
      check32("rv_pre_out",   out, 32'h8000_2000);
      do_redirect(32'h8000_3000);
      check32("rv_flushed", {31'b0, ifu_valid}, 32'd0);
      push_exp(32'h8000_3000, 1'b0);
      push_exp(32'h8000_3004, 1'b0);
      idu_ready = 1'b1;
      t = pop_cnt + 2;
      wait_pops(t, 100);

      // Bus error halts fetch until a redirect.
      tick(20);
      exp_q.delete();
      err_addr = 32'h8000_0008;
      err_en   = 1;
      do_redirect(32'h8000_0000);
      n = ar_q.size();
      tick(30);
      check32("err_ar_count", ar_q.size() - n, 32'd3);
      check32("err_arvalid",  {31'b0, ifu_arvalid}, 32'd0);
      push_exp(32'h8000_0000, 1'b0);
      push_exp(32'h8000_0004, 1'b0);
      push_exp(32'h8000_0008, 1'b1);
      idu_ready = 1'b1;
      t = pop_cnt + 3;
      wait_pops(t, 100);
      err_en = 0;
      push_exp(32'h8000_0000, 1'b0);
      push_exp(32'h8000_0004, 1'b0);
      do_redirect(32'h8000_0000);
      idu_ready = 1'b1;
      t = pop_cnt + 2;
      wait_pops(t, 100);

      // PC wraps past the top of the address space.
      tick(20);
      exp_q.delete();
      do_redirect(32'hFFFF_FFF8);
      push_exp(32'hFFFF_FFF8, 1'b0);
      push_exp(32'hFFFF_FFFC, 1'b0);
      push_exp(32'h0000_0000, 1'b0);
      push_exp(32'h0000_0004, 1'b0);
      idu_ready = 1'b1;
      t = pop_cnt + 4;
      wait_pops(t, 100);

      // Reset in the middle of a stalled request.
      tick(20);
      ar_stall = 1;
      exp_q.delete();
      do_redirect(32'h8000_4000);
      tick(3);
      check32("mid_arvalid", {31'b0, ifu_arvalid}, 32'd1);
      check32("mid_araddr",  ifu_araddr, 32'h8000_4000);
      rst = 1'b1;
      #1;
      check32("mrst_arvalid", {31'b0, ifu_arvalid}, 32'd0);
      check32("mrst_valid",   {31'b0, ifu_valid}, 32'd0);
      check32("mrst_araddr",  ifu_araddr, 32'h8000_0000);
      tick(2);
      ar_stall = 0;
      rst      = 1'b0;
      tick(1);
      check32("post_rst_arvalid", {31'b0, ifu_arvalid}, 32'd1);
      check32("post_rst_araddr",  ifu_araddr, 32'h8000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
